vga_scandoubler: RTL and testbench

Line-doubling stage downstream of the Vector-06C video generator. It takes the 12 MHz, 15.6 kHz pixel stream (3-bit R/G/B, syncs, blanks) and emits each source line twice at 24 MHz pixel rate for 31 kHz VGA monitors. Two line buffers are used in ping-pong: one is written while the other is read twice. There is optional scanline attenuation and a bypass mode.

---
 rtl/vga_scandoubler.sv | 132 +++++++++++++
 tb/tb_vga_scandoubler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_scandoubler.sv
// Line doubler for the 15.6 kHz video stream: each source line is buffered and
// replayed twice at the 2x pixel rate, with optional scanline dimming and bypass.
module vga_scandoubler #(
  parameter int ADDR_W  = 10,
  parameter int DEF_LEN = 768,
  parameter int DEF_HSW = 56
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       ce_pix2x,
  input  logic       enable,
  input  logic [1:0] scanlines,
  input  logic [2:0] r_in, g_in, b_in,
  input  logic       hs_in, vs_in, hb_in, vb_in,
  output logic [2:0] r_out, g_out, b_out,
  output logic       hs_out, vs_out, hb_out, vb_out
);
  localparam int LW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] HMAX    = '1;
  localparam logic [ADDR_W-1:0] A1      = ADDR_W'(1);
  localparam logic [LW-1:0]     L1      = LW'(1);
  localparam logic [LW-1:0]     MIN_LEN = LW'(64);

  typedef struct packed { logic vb; logic hb; logic [2:0] b, g, r; } pix_t;
  typedef struct packed { logic hs; logic vs; logic pass; logic blank; } ctl_t;

  pix_t mem [2**LW];
  pix_t wr_pix, rd_pix;
  ctl_t ctl;

  logic              hs_prev, wbank, en_q, hs_rise, primed;
  logic [1:0]        n_rise;
  logic [ADDR_W-1:0] hcnt_in, hcnt_out;
  logic [LW-1:0]     line_len, hs_cnt, hs_width, len_meas, half_len;
  logic              pass, hold, vs_line, at_end;

  assign hs_rise  = ce_pix & hs_in & ~hs_prev;
  assign len_meas = {1'b0, hcnt_in} + L1;
  assign half_len = line_len >> 1;
  assign wr_pix   = {vb_in, hb_in, b_in, g_in, r_in};
  assign primed   = (n_rise == 2'd2);
  assign at_end   = {1'b0, hcnt_out} >= line_len - L1;

  // Input side: line measurement and buffer write address.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_prev  <= 1'b0;
      hcnt_in  <= '0;
      wbank    <= 1'b0;
      n_rise   <= '0;
      line_len <= LW'(DEF_LEN);
      hs_width <= LW'(DEF_HSW);
      hs_cnt   <= '0;
      en_q     <= 1'b1;
    end else if (ce_pix) begin
      hs_prev <= hs_in;
      en_q    <= enable;
      if (hs_rise) begin
        line_len <= (len_meas < MIN_LEN) ? MIN_LEN : len_meas;
        hcnt_in  <= '0;
        wbank    <= ~wbank;
        hs_cnt   <= L1;
        if (!primed) n_rise <= n_rise + 2'd1;
      end else begin
        if (hcnt_in != HMAX) hcnt_in <= hcnt_in + A1;
        if (hs_in && hs_cnt != '1) hs_cnt <= hs_cnt + L1;
        if (!hs_in && hs_prev)
          hs_width <= (hs_cnt == '0) ? L1 : (hs_cnt > half_len) ? half_len : hs_cnt;
      end
    end
  end

  // The last address stays unwritten so an overlong line cannot wrap onto its start.
  always_ff @(posedge clk_sys)
    if (!reset && ce_pix && hcnt_in != HMAX) mem[{wbank, hcnt_in}] <= wr_pix;

  // Output side: two passes over the previous line; an input hs edge always resyncs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt_out <= '0;
      pass     <= 1'b0;
      hold     <= 1'b0;
      vs_line  <= 1'b0;
    end else if (ce_pix2x) begin
      if (hs_rise) begin
        hcnt_out <= '0;
        pass     <= 1'b0;
        hold     <= 1'b0;
        vs_line  <= vs_in;
      end else if (!at_end) begin
        hcnt_out <= hcnt_out + A1;
      end else if (!pass) begin
        hcnt_out <= '0;
        pass     <= 1'b1;
        vs_line  <= vs_in;
      end else begin
        hold <= 1'b1;
      end
    end
  end

  // RAM read stage; sync/pass/blank ride alongside to stay aligned with the data.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_pix <= '0;
      ctl    <= '{hs: 1'b0, vs: 1'b0, pass: 1'b0, blank: 1'b1};
    end else if (ce_pix2x) begin
      rd_pix <= mem[{~wbank, hcnt_out}];
      ctl    <= '{hs: ({1'b0, hcnt_out} < hs_width), vs: vs_line, pass: pass,
                  blank: hold | ~primed};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      {r_out, g_out, b_out}            <= '0;
      {hs_out, vs_out, hb_out, vb_out} <= '0;
    end else if (ce_pix && !enable) begin
      {r_out, g_out, b_out}            <= {r_in, g_in, b_in};
      {hs_out, vs_out, hb_out, vb_out} <= {hs_in, vs_in, hb_in, vb_in};
    end else if (ce_pix2x && (ce_pix ? enable : en_q)) begin
      r_out  <= ctl.pass ? rd_pix.r >> scanlines : rd_pix.r;
      g_out  <= ctl.pass ? rd_pix.g >> scanlines : rd_pix.g;
      b_out  <= ctl.pass ? rd_pix.b >> scanlines : rd_pix.b;
      hs_out <= ctl.hs;
      vs_out <= ctl.vs;
      hb_out <= rd_pix.hb | ctl.blank;
      vb_out <= rd_pix.vb | ctl.blank;
    end
  end
endmodule

// File: tb/tb_vga_scandoubler.sv
// Randomized bench: a line-level model predicts every output tick; a monitor
// compares the DUT against the queued predictions.
module tb_vga_scandoubler;
  localparam int NPIX = 1024, DEF_LEN = 768, DEF_HSW = 56;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1, ce_pix = 1'b0, ce_pix2x = 1'b0, enable = 1'b1;
  logic [1:0] scanlines = '0;
  logic [2:0] r_in = '0, g_in = '0, b_in = '0;
  logic       hs_in = 1'b0, vs_in = 1'b0, hb_in = 1'b0, vb_in = 1'b0;
  logic [2:0] r_out, g_out, b_out;
  logic       hs_out, vs_out, hb_out, vb_out;

  vga_scandoubler dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .ce_pix2x(ce_pix2x),
    .enable(enable), .scanlines(scanlines),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed { logic [2:0] r, g, b; logic hs, vs, hb, vb; } obs_t;
  typedef struct { obs_t v; obs_t care; } exp_t;
  typedef struct { bit [10:0] pix; bit known, pass, hs, vs, blank; } rec_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_bad = 0;

  // Reference model: two line stores plus "ticks since the last hs edge".
  bit [10:0] mm [2][NPIX];
  bit        mv [2][NPIX];
  int        t, len_m, hsw_m, hin, hscnt, nrise;
  bit        wb, hsp, vs0, vs1, en_m;
  rec_t      prev;
  exp_t      last;
  bit        en_cfg = 1'b1;
  bit [1:0]  sl_cfg = '0;

  task automatic model_reset();
    t = 0; len_m = DEF_LEN; hsw_m = DEF_HSW; hin = 0; hscnt = 0; nrise = 0;
    wb = 0; hsp = 0; vs0 = 0; vs1 = 0; en_m = 1;
    prev = '{pix: '0, known: 1, pass: 0, hs: 0, vs: 0, blank: 1};
    last.v = '0; last.care = '1;
  endtask

  task automatic model_tick(input bit cp);
    rec_t cur; exp_t e; int hc; bit [1:0] sh; bit rose;
    cur.pass  = (t >= len_m);
    hc        = (t < len_m) ? t : (t < 2 * len_m) ? t - len_m : len_m - 1;
    cur.pix   = mm[!wb][hc];
    cur.known = mv[!wb][hc];
    cur.hs    = (hc < hsw_m);
    cur.vs    = cur.pass ? vs1 : vs0;
    cur.blank = (nrise < 2) || (t >= 2 * len_m);
    if (cp) en_m = enable;
    if (cp && !enable) begin
      e.v = {r_in, g_in, b_in, hs_in, vs_in, hb_in, vb_in};
      e.care = '1;
    end else if (en_m) begin
      sh = prev.pass ? scanlines : 2'd0;
      e.v.r = prev.pix[2:0] >> sh;
      e.v.g = prev.pix[5:3] >> sh;
      e.v.b = prev.pix[8:6] >> sh;
      e.v.hs = prev.hs;
      e.v.vs = prev.vs;
      e.v.hb = prev.blank | prev.pix[9];
      e.v.vb = prev.blank | prev.pix[10];
      e.care = '1;
      if (!prev.known) begin
        e.care.r = '0; e.care.g = '0; e.care.b = '0;
        if (!prev.blank) begin e.care.hb = 1'b0; e.care.vb = 1'b0; end
      end
    end else begin
      e = last;
    end
    last = e;
    prev = cur;
    sb_q.push_back(e);
    rose = 0;
    if (cp) begin
      if (hin != NPIX - 1) begin
        mm[wb][hin] = {vb_in, hb_in, b_in, g_in, r_in};
        mv[wb][hin] = 1;
      end
      if (hs_in && !hsp) begin
        rose = 1;
        len_m = (hin + 1 < 64) ? 64 : hin + 1;
        wb = !wb; hin = 0; hscnt = 1; t = 0; vs0 = vs_in;
        if (nrise < 2) nrise++;
      end else begin
        if (hin != NPIX - 1) hin++;
        if (hs_in && hscnt < 2047) hscnt++;
        if (!hs_in && hsp) hsw_m = (hscnt < 1) ? 1 : (hscnt > len_m / 2) ? len_m / 2 : hscnt;
      end
      hsp = hs_in;
    end
    if (!rose) begin
      if (t < 2 * len_m) t++;
      if (t == len_m) vs1 = vs_in;
    end
  endtask

  // Monitor: one prediction is consumed per output tick.
  always @(posedge clk_sys) begin
    bit fire; exp_t e; obs_t o;
    fire = ce_pix2x && !reset;
    #1;
    if (fire) begin
      o = {r_out, g_out, b_out, hs_out, vs_out, hb_out, vb_out};
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: output tick %0d with no prediction", n_cmp);
      end else begin
        e = sb_q.pop_front();
        if (((o ^ e.v) & e.care) != '0) begin
          n_bad++;
          $display("FAIL out_tick %0d: got rgb/hs/vs/hb/vb=%h want %h (care %h)",
                   n_cmp, o, e.v, e.care);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [8:0] got, input logic [8:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic idle();
    @(negedge clk_sys); ce_pix = 0; ce_pix2x = 0;
  endtask

  task automatic pixel(input bit [2:0] r, g, b, input bit hs, vs, hb, vb);
    @(negedge clk_sys);
    r_in = r; g_in = g; b_in = b; hs_in = hs; vs_in = vs; hb_in = hb; vb_in = vb;
    enable = en_cfg; scanlines = sl_cfg;
    ce_pix = 1; ce_pix2x = 1;
    model_tick(1);
    if ($urandom_range(0, 3) == 0) idle();
    @(negedge clk_sys); ce_pix = 0; ce_pix2x = 1;
    model_tick(0);
    if ($urandom_range(0, 3) == 0) idle();
  endtask

  // mode 0: hcnt mod 8, 1: constant 110, 2: random colour
  task automatic line(input int len, hs_start, hs_w, mode, input bit vs, input int flip);
    for (int k = 0; k < len; k++) begin
      bit [2:0] cr, cg, cb;
      if (k == flip) en_cfg = ~en_cfg;
      case (mode)
        0:       begin cr = 3'(k % 8); cg = cr; cb = cr; end
        1:       begin cr = 3'b110; cg = cr; cb = cr; end
        default: begin cr = 3'($urandom); cg = 3'($urandom); cb = 3'($urandom); end
      endcase
      pixel(cr, cg, cb, (k >= hs_start) && (k < hs_start + hs_w), vs,
            (k % 97) < 10, (k % 211) < 3);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys); reset = 1; ce_pix = 0; ce_pix2x = 0;
    repeat (3) @(negedge clk_sys);
    check("reset_rgb", {r_out, g_out, b_out}, 9'd0);
    check("reset_sync", {7'd0, hs_out, vs_out}, 9'd0);
    check("reset_blank", {7'd0, hb_out, vb_out}, 9'd0);
    reset = 0;
    model_reset();
  endtask

  initial begin
    for (int b = 0; b < 2; b++) for (int a = 0; a < NPIX; a++) mv[b][a] = 0;
    model_reset();
    do_reset();
    // steady state, priming blank through the first output line
    repeat (3) line(768, 597, 56, 0, 0, -1);
    sl_cfg = 1; repeat (2) line(768, 597, 56, 1, 1, -1);
    sl_cfg = 3; repeat (2) line(768, 597, 56, 1, 0, -1);
    sl_cfg = 0;
    // shortened line forces a resync, then 700-pixel lines
    repeat (3) line(700, 597, 56, 0, 1, -1);
    // reset mid-line, then re-prime from stale buffers
    line(300, 597, 56, 2, 0, -1);
    do_reset();
    repeat (3) line(768, 597, 56, 0, 0, -1);
    // bypass entered and left mid-line
    line(768, 597, 56, 2, 1, 100);
    line(768, 597, 56, 2, 0, 400);
    line(768, 597, 56, 2, 1, -1);
    // overlong line saturates the write counter
    line(1100, 597, 0, 2, 0, -1);
    repeat (2) line(768, 597, 56, 0, 1, -1);
    // random lengths, widths, scanlines; includes sub-64 lines and wide hsync
    repeat (8) begin
      int len;
      len = $urandom_range(20, 900);
      sl_cfg = 2'($urandom);
      line(len, 4, $urandom_range(1, len - 8), 2, 1'($urandom), -1);
    end
    sl_cfg = 0;
    line(768, 597, 56, 0, 0, -1);
    repeat (4) idle();
    check("sb_drained", 9'(sb_q.size()), 9'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
